// File: rtl/seq_div_unit.sv
// Multi-cycle restoring divider: one quotient bit per cycle, RISC-V DIV/DIVU/REM/REMU results,
// valid/ready handshake on both the issue and the result side.
module seq_div_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic [WIDTH-1:0]   quotient_q, quotient_d;
    logic [WIDTH-1:0]   remainder_q, remainder_d;
    logic               dbz_q, dbz_d;

    logic [WIDTH-1:0]   dvd_abs, dvs_abs;
    logic [WIDTH:0]     rem_sh;
    logic               borrow;
    logic [WIDTH-1:0]   rem_nxt, quo_nxt;

    always_comb begin
        dvd_abs = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
        dvs_abs = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

        // Shifted partial remainder kept one bit wider so divisors above 2^(WIDTH-1) still
        // compare correctly; whichever value is kept is below the divisor and fits WIDTH bits.
        rem_sh  = {rem_q, quo_q[WIDTH-1]};
        borrow  = rem_sh < {1'b0, dvs_q};
        rem_nxt = borrow ? rem_sh[WIDTH-1:0] : (rem_sh[WIDTH-1:0] - dvs_q);
        quo_nxt = {quo_q[WIDTH-2:0], ~borrow};

        state_d     = state_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        cnt_d       = cnt_q;
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dvs_d  = dvs_abs;
                    qneg_d = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    rneg_d = is_signed & dividend[WIDTH-1];
                    if (divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        state_d     = DONE;
                    end else begin
                        rem_d   = '0;
                        quo_d   = dvd_abs;
                        cnt_d   = CNT_W'(WIDTH);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = rem_nxt;
                quo_d = quo_nxt;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    quotient_d  = qneg_q ? -quo_nxt : quo_nxt;
                    remainder_d = rneg_q ? -rem_nxt : rem_nxt;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    dbz_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
            qneg_q      <= qneg_d;
            rneg_q      <= rneg_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div_unit.sv
// Directed-vector bench for seq_div_unit with hand-computed quotients, remainders and latencies.
module tb_seq_div_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        is_signed;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int n_tests = 0;
    int n_fail  = 0;

    seq_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .is_signed   (is_signed),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present operands for one edge, then scramble them to show they are no longer sampled.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge clk);
        check("in_ready_before_issue", 32'(in_ready), 32'd1);
        dividend  = a;
        divisor   = b;
        is_signed = s;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
        is_signed = 1'($urandom);
    endtask

    // Latency counts the handshake edge as cycle 1; sampled on falling edges.
    task automatic wait_out(output int lat);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic retire();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("out_valid_after_retire", 32'(out_valid), 32'd0);
        check("dbz_after_retire", 32'(div_by_zero), 32'd0);
        check("in_ready_after_retire", 32'(in_ready), 32'd1);
    endtask

    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [31:0] eq, input logic [31:0] er, input logic ez, input int elat);
        int lat;
        issue(a, b, s);
        wait_out(lat);
        check({tag, "_lat"}, 32'(lat), 32'(elat));
        check({tag, "_q"}, quotient, eq);
        check({tag, "_r"}, remainder, er);
        check({tag, "_dbz"}, 32'(div_by_zero), 32'(ez));
        check({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
        retire();
    endtask

    initial begin
        int lat;
        int stale;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        dividend  = '0;
        divisor   = '0;
        is_signed = 1'b0;
        out_ready = 1'b0;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_q", quotient, 32'd0);
        check("rst_r", remainder, 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run("udiv_100_7",   32'd100,      32'd7,        1'b0, 32'd14,       32'd2,        1'b0, 33);
        run("sdiv_m7_2",    32'hFFFFFFF9, 32'd2,        1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33);
        run("sdiv_7_m2",    32'd7,        32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1,        1'b0, 33);
        run("udiv_m7_2",    32'hFFFFFFF9, 32'd2,        1'b0, 32'h7FFFFFFC, 32'd1,        1'b0, 33);
        run("div0",         32'h1234,     32'd0,        1'b0, 32'hFFFFFFFF, 32'h1234,     1'b1, 1);
        run("sdiv0_neg",    32'hFFFFFFF9, 32'd0,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1, 1);
        run("sovf",         32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0,        1'b0, 33);
        run("udiv_bigdvs",  32'hFFFFFFFF, 32'h80000001, 1'b0, 32'd1,        32'h7FFFFFFE, 1'b0, 33);
        run("udiv_small",   32'd3,        32'd10,       1'b0, 32'd0,        32'd3,        1'b0, 33);

        // Result held under backpressure while the issue side churns.
        issue(32'd1000, 32'd10, 1'b0);
        wait_out(lat);
        check("bp_lat", 32'(lat), 32'd33);
        for (int i = 0; i < 5; i++) begin
            in_valid  = 1'(i % 2);
            dividend  = $urandom;
            divisor   = $urandom;
            is_signed = 1'($urandom);
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_q", quotient, 32'd100);
            check("bp_r", remainder, 32'd0);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        retire();
        run("bp_next", 32'hFFFFFFFF, 32'h10, 1'b0, 32'h0FFFFFFF, 32'hF, 1'b0, 33);

        // Asynchronous reset part-way through an operation.
        issue(32'd100, 32'd7, 1'b0);
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_q", quotient, 32'd0);
        check("arst_r", remainder, 32'd0);
        check("arst_dbz", 32'(div_by_zero), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid || !in_ready) stale++;
        end
        check("arst_no_stale", 32'(stale), 32'd0);
        run("post_rst", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 33);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
